// File: rtl/adda_pkg.sv
// adda_pkg: shared defaults, midscale helper and upsampler FSM state encoding.
package adda_pkg;
   localparam int DEF_DATA_WIDTH = 14;
   localparam int DEF_SAMPLE_RATE = 4;
   typedef enum logic [2:0] {IDLE, LOAD1, FETCH2, LOAD2, RUN} state_t;
   function automatic int unsigned midscale(input int dw);
      return 32'd1 << (dw - 1);
   endfunction
endpackage

// File: rtl/interp_upsampler_if.sv
// interp_upsampler_if: FIFO-side and DAC-side signals of the interpolating upsampler.
interface interp_upsampler_if #(parameter int DW = 14) ();
   logic ena, fifo_empty, rd_en, data_valid, underrun;
   logic [DW-1:0] dataIn, inter_data;
   modport master (input ena, fifo_empty, dataIn, output rd_en, inter_data, data_valid, underrun);
   modport slave (output ena, fifo_empty, dataIn, input rd_en, inter_data, data_valid, underrun);
endinterface

// File: rtl/interp_datapath.sv
// interp_datapath: P/C segment endpoints and per-phase accumulate producing the registered DAC sample.
module interp_datapath
   import adda_pkg::*;
#(
   parameter int DW = DEF_DATA_WIDTH,
   parameter int L = DEF_SAMPLE_RATE
) (
   input logic clk,
   input logic rst,
   input logic load_p,
   input logic load_c,
   input logic shift,
   input logic first,
   input logic run,
   input logic [DW-1:0] din,
   output logic [DW-1:0] inter_data
);
   localparam int LW = $clog2(L);
   localparam int AW = DW + LW + 1;
   localparam logic [DW-1:0] MID = DW'(midscale(DW));
   logic [DW-1:0] p, c;
   logic signed [DW:0] diff;
   logic signed [AW-1:0] acc, acc_q;
   assign diff = $signed({1'b0, c}) - $signed({1'b0, p});
   // acc = P*L + phase*diff, built by adding diff once per phase
   assign acc = first ? $signed({1'b0, p, {LW{1'b0}}}) : acc_q + AW'(diff);
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         p <= MID;
         c <= MID;
         acc_q <= '0;
         inter_data <= MID;
      end else begin
         if (load_p || shift) p <= load_p ? din : c;
         if (load_c) c <= din;
         acc_q <= acc;
         inter_data <= run ? acc[AW-2:LW] : c;
      end
endmodule

// File: rtl/interp_upsampler.sv
// interp_upsampler: pops one FIFO sample per SAMPLE_RATE clocks and emits a linearly
// interpolated sample every clock to the DAC.
module interp_upsampler
   import adda_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int SAMPLE_RATE = DEF_SAMPLE_RATE
) (
   input logic clk,
   input logic rst,
   interp_upsampler_if.master bus
);
   localparam int LOG2_L = $clog2(SAMPLE_RATE);
   state_t state, state_nxt;
   logic [LOG2_L-1:0] phase;
   logic fetched, rd, run, wrap;
   assign run = state == RUN;
   assign wrap = run && phase == LOG2_L'(SAMPLE_RATE - 1);
   always_comb begin
      state_nxt = state;
      rd = 1'b0;
      case (state)
         IDLE: begin
            rd = bus.ena;
            state_nxt = bus.ena && !bus.fifo_empty ? LOAD1 : IDLE;
         end
         LOAD1: state_nxt = FETCH2;
         FETCH2: begin
            rd = 1'b1;
            state_nxt = bus.fifo_empty ? FETCH2 : LOAD2;
         end
         LOAD2: state_nxt = RUN;
         RUN: begin
            rd = bus.ena && phase == LOG2_L'(SAMPLE_RATE - 2);
            state_nxt = wrap && !fetched && !bus.ena ? IDLE : RUN;
         end
         default: state_nxt = IDLE;
      endcase
   end
   assign bus.rd_en = rst && rd && !bus.fifo_empty;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         phase <= '0;
         fetched <= 1'b0;
         bus.data_valid <= 1'b0;
         bus.underrun <= 1'b0;
      end else begin
         state <= state_nxt;
         phase <= run ? phase + 1'b1 : '0;
         fetched <= run && bus.rd_en;
         bus.data_valid <= run;
         bus.underrun <= wrap && !fetched && bus.ena;
      end
   // a prefetched sample lands on dataIn exactly in the wrap cycle, so C loads straight from it
   interp_datapath #(.DW(DATA_WIDTH), .L(SAMPLE_RATE)) u_dp (
      .clk(clk),
      .rst(rst),
      .load_p(state == LOAD1),
      .load_c(state == LOAD2 || (wrap && fetched)),
      .shift(wrap && (fetched || bus.ena)),
      .first(phase == '0),
      .run(run),
      .din(bus.dataIn),
      .inter_data(bus.inter_data)
   );
endmodule

// File: tb/tb_interp_upsampler.sv
// tb_interp_upsampler: directed vectors against a 1-cycle-latency FIFO model, DW=14, L=4.
module tb_interp_upsampler;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int checks = 0;
   int failures = 0;
   int rd_cnt, ur_cnt;
   int fifo_q[$];
   int exp_q[$];
   interp_upsampler_if #(.DW(14)) bus ();
   interp_upsampler #(.DATA_WIDTH(14), .SAMPLE_RATE(4)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   assign bus.fifo_empty = fifo_q.size() == 0;
   always @(posedge clk)
      if (bus.rd_en && fifo_q.size() > 0) bus.dataIn <= 14'(fifo_q.pop_front());
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask
   task automatic do_reset();
      rst = 1'b0;
      bus.ena = 1'b0;
      fifo_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask
   task automatic wait_valid(input string tag);
      int n = 0;
      while (!bus.data_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_start"}, 32'(bus.data_valid), 1);
   endtask
   task automatic check_stream(input string tag);
      rd_cnt = 0;
      ur_cnt = 0;
      foreach (exp_q[i]) begin
         chk($sformatf("%s[%0d]", tag, i), 32'(bus.inter_data), exp_q[i]);
         rd_cnt += int'(bus.rd_en);
         ur_cnt += int'(bus.underrun);
         @(negedge clk);
      end
   endtask
   task automatic run_case(input string tag);
      bus.ena = 1'b1;
      wait_valid(tag);
      check_stream(tag);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
   initial begin
      bus.ena = 1'b1;
      bus.dataIn = '0;
      fifo_q = '{77};
      #12;
      chk("rst_data", 32'(bus.inter_data), 8192);
      chk("rst_rd", 32'(bus.rd_en), 0);
      chk("rst_dv", 32'(bus.data_valid), 0);
      chk("rst_ur", 32'(bus.underrun), 0);
      do_reset();
      fifo_q = '{1000, 2000, 3000};
      exp_q = '{1000, 1250, 1500, 1750, 2000, 2250, 2500, 2750, 3000, 3000, 3000, 3000};
      run_case("ramp");
      chk("ramp_rd", rd_cnt, 1);
      chk("ramp_ur", ur_cnt, 2);
      do_reset();
      fifo_q = '{1000, 2000};
      exp_q = '{1000, 1250, 1500, 1750, 2000, 2000, 2000, 2000};
      run_case("under");
      chk("under_rd", rd_cnt, 0);
      chk("under_ur", ur_cnt, 2);
      do_reset();
      fifo_q = '{2000, 1000};
      exp_q = '{2000, 1750, 1500, 1250};
      run_case("down");
      do_reset();
      fifo_q = '{1, 0};
      exp_q = '{1, 0, 0, 0};
      run_case("floor");
      do_reset();
      fifo_q = '{0, 16383};
      exp_q = '{0, 4095, 8191, 12287, 16383};
      run_case("fs_up");
      do_reset();
      fifo_q = '{16383, 0};
      exp_q = '{16383, 12287, 8191, 4095, 0};
      run_case("fs_dn");
      do_reset();
      fifo_q = '{0, 400, 800};
      exp_q = '{0, 100, 200, 300, 400};
      bus.ena = 1'b1;
      wait_valid("drop");
      bus.ena = 1'b0;
      check_stream("drop");
      chk("drop_rd", rd_cnt, 0);
      chk("drop_ur", ur_cnt, 0);
      chk("drop_dv", 32'(bus.data_valid), 0);
      repeat (4) @(negedge clk);
      chk("drop_hold", 32'(bus.inter_data), 400);
      chk("drop_idle_rd", 32'(bus.rd_en), 0);
      fifo_q.push_back(1200);
      exp_q = '{800, 900, 1000, 1100};
      run_case("reprime");
      do_reset();
      fifo_q = '{1000, 2000, 3000, 4000};
      bus.ena = 1'b1;
      wait_valid("arst");
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("arst_data", 32'(bus.inter_data), 8192);
      chk("arst_rd", 32'(bus.rd_en), 0);
      chk("arst_dv", 32'(bus.data_valid), 0);
      fifo_q.delete();
      @(negedge clk);
      fifo_q = '{500, 1500};
      rst = 1'b1;
      exp_q = '{500, 750, 1000, 1250};
      run_case("restart");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
